// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if
// Purpose : groups the request/result signals of the bit-serial adder/subtractor
//           so the block and its user share one bundle.
// Signals : start           - begin an operation (honoured only while idle)
//           mode            - 0 = add, 1 = subtract
//           a_input/b_input - two's complement operands, WIDTH bits
//           c_in            - carry-in (add) or borrow-in (subtract)
//           sum             - WIDTH-bit result
//           carry_out       - raw carry out of the MSB stage
//           overflow        - signed overflow flag
//           busy            - high while bits are being processed
//           done            - one-cycle pulse when results become valid
// Modports: master drives the request side, slave is the adder itself.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a_input;
    logic [WIDTH-1:0] b_input;
    logic             c_in;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, a_input, b_input, c_in,
        input  sum, carry_out, overflow, busy, done
    );

    modport slave (
        input  start, mode, a_input, b_input, c_in,
        output sum, carry_out, overflow, busy, done
    );
endinterface

// File: rtl/serial_add_sub.sv
// serial_add_sub
// Purpose : bit-serial two's complement adder/subtractor. One operand bit is
//           processed per clock, LSB first, through a single full-adder cell
//           with a registered carry. WIDTH processing cycles follow the
//           accepting edge, then a one-cycle done pulse.
// Ports   : clk   - clock, all state changes on the rising edge
//           rst_n - synchronous active-low reset
//           bus   - serial_add_sub_if slave modport (request and results)
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_add_sub_if.slave bus
);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             mode_reg;
    logic             carry_reg;
    logic             carry_out_reg;
    logic             overflow_reg;
    logic [CW-1:0]    bit_count;
    logic             b_bit;
    logic             sum_bit;
    logic             carry_bit;

    // Single full-adder cell. Subtraction feeds the inverted B bit; the
    // matching +1 comes from the initial carry loaded at accept time.
    always_comb begin
        b_bit     = b_reg[0] ^ mode_reg;
        sum_bit   = a_reg[0] ^ b_bit ^ carry_reg;
        carry_bit = (a_reg[0] & b_bit) | (carry_reg & (a_reg[0] ^ b_bit));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start only matters in IDLE, so requests during RUN
    // or DONE are dropped rather than queued.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (bit_count == LAST_BIT) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath. Operands are latched on the accepting edge and shifted right
    // each RUN cycle, so bit 0 always holds the bit being processed. The sum
    // shifts in from the top and ends up aligned after WIDTH cycles. The
    // flags are captured on the MSB step, where carry_reg is the carry into
    // the MSB and carry_bit the carry out of it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            mode_reg      <= 1'b0;
            carry_reg     <= 1'b0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            bit_count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg     <= bus.a_input;
                        b_reg     <= bus.b_input;
                        mode_reg  <= bus.mode;
                        carry_reg <= bus.c_in ^ bus.mode;
                        bit_count <= '0;
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    sum_reg   <= {sum_bit, sum_reg[WIDTH-1:1]};
                    carry_reg <= carry_bit;
                    bit_count <= bit_count + 1'b1;
                    if (bit_count == LAST_BIT) begin
                        carry_out_reg <= carry_bit;
                        overflow_reg  <= carry_bit ^ carry_reg;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.sum       = sum_reg;
    assign bus.carry_out = carry_out_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub
// Purpose : self-checking bench for serial_add_sub at WIDTH 8, 2 and 32, with
//           an array of WIDTH=8 lanes sweeping every {mode, c_in, a, b}.
// Ports   : none (top-level bench).
module tb_serial_add_sub;

    localparam int LANES = 64;

    typedef struct {
        logic [31:0] sum;
        logic        co;
        logic        ov;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    exp_t sb8[$];
    exp_t sb2[$];
    exp_t sb32[$];
    exp_t sb_lane[$];

    serial_add_sub_if #(.WIDTH(8))  bus8 ();
    serial_add_sub_if #(.WIDTH(2))  bus2 ();
    serial_add_sub_if #(.WIDTH(32)) bus32 ();

    serial_add_sub #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_add_sub #(.WIDTH(2))  u_dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));
    serial_add_sub #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    logic       lane_start;
    logic       lane_mode [LANES];
    logic [7:0] lane_a    [LANES];
    logic [7:0] lane_b    [LANES];
    logic       lane_cin  [LANES];
    logic [7:0] lane_sum  [LANES];
    logic       lane_co   [LANES];
    logic       lane_ov   [LANES];
    logic       lane_done [LANES];

    // Parallel lanes so the full operand sweep fits in a short run.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        serial_add_sub_if #(.WIDTH(8)) lane_if ();
        assign lane_if.start   = lane_start;
        assign lane_if.mode    = lane_mode[g];
        assign lane_if.a_input = lane_a[g];
        assign lane_if.b_input = lane_b[g];
        assign lane_if.c_in    = lane_cin[g];
        assign lane_sum[g]     = lane_if.sum;
        assign lane_co[g]      = lane_if.carry_out;
        assign lane_ov[g]      = lane_if.overflow;
        assign lane_done[g]    = lane_if.done;
        serial_add_sub #(.WIDTH(8)) u_dut (.clk(clk), .rst_n(rst_n), .bus(lane_if));
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference: unsigned result for sum/carry, true signed
    // result range-checked for overflow.
    function automatic exp_t model(input int w, input bit m, input logic [31:0] a,
                                   input logic [31:0] b, input bit cin);
        exp_t   e;
        longint one, mask, ua, ub, sa, sb, c, ures, sres, smax, smin;
        one  = 1;
        mask = (one << w) - one;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        c    = cin ? one : 0;
        sa   = (ua >= (one << (w - 1))) ? ua - (one << w) : ua;
        sb   = (ub >= (one << (w - 1))) ? ub - (one << w) : ub;
        smax = (one << (w - 1)) - one;
        smin = -(one << (w - 1));
        if (!m) begin
            ures = ua + ub + c;
            sres = sa + sb + c;
            e.co = (ures > mask);
        end else begin
            ures = ua - ub - c;
            sres = sa - sb - c;
            e.co = (ua >= ub + c);
        end
        e.sum = 32'(ures & mask);
        e.ov  = (sres > smax) || (sres < smin);
        return e;
    endfunction

    // Drives one request on the WIDTH=8 DUT from an IDLE negedge, records
    // the expectation, and scrambles the inputs after the accepting edge.
    task automatic start_op8(input bit m, input logic [7:0] a, input logic [7:0] b,
                             input bit cin, input exp_t e);
        bus8.mode    = m;
        bus8.a_input = a;
        bus8.b_input = b;
        bus8.c_in    = cin;
        bus8.start   = 1'b1;
        sb8.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus8.start   = 1'b0;
        bus8.mode    = 1'($urandom);
        bus8.a_input = 8'($urandom);
        bus8.b_input = 8'($urandom);
        bus8.c_in    = 1'($urandom);
    endtask

    // Waits for done on the WIDTH=8 DUT; cyc counts negedges from the
    // accepting edge (1 = first RUN cycle), bounded.
    task automatic wait_done8(output int cyc);
        cyc = 1;
        while (bus8.done !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        bus8.start   = 1'b1;
        bus8.mode    = 1'b0;
        bus8.a_input = 8'h55;
        bus8.b_input = 8'h66;
        bus8.c_in    = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus8.busy, bus8.done, bus8.sum, bus8.carry_out, bus8.overflow} !== 12'h000) begin
            failures++;
            $display("[TB] FAIL reset_state8: busy=%b done=%b sum=%h co=%b ov=%b, want all 0",
                     bus8.busy, bus8.done, bus8.sum, bus8.carry_out, bus8.overflow);
        end
        checks++;
        if ({bus2.busy, bus2.done, bus2.sum, bus32.busy, bus32.done, bus32.sum} !== 38'h0) begin
            failures++;
            $display("[TB] FAIL reset_state_w2_w32: w2 busy=%b done=%b sum=%h w32 busy=%b done=%b sum=%h, want 0",
                     bus2.busy, bus2.done, bus2.sum, bus32.busy, bus32.done, bus32.sum);
        end
        bus8.start = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        checks++;
        if (bus8.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_start_ignored: busy=%b, want 0", bus8.busy);
        end
    endtask

    task automatic test_add;
        logic [7:0] op_a [3] = '{8'h3C, 8'hFF, 8'h7F};
        logic [7:0] op_b [3] = '{8'h05, 8'h01, 8'h01};
        bit         op_c [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] e_s  [3] = '{8'h41, 8'h01, 8'h80};
        bit         e_co [3] = '{1'b0, 1'b1, 1'b0};
        bit         e_ov [3] = '{1'b0, 1'b0, 1'b1};
        exp_t       e;
        int         cyc;
        for (int i = 0; i < 3; i++) begin
            start_op8(1'b0, op_a[i], op_b[i], op_c[i], '{32'(e_s[i]), e_co[i], e_ov[i]});
            checks++;
            if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL add_busy case %0d: busy=%b done=%b, want busy=1 done=0",
                         i, bus8.busy, bus8.done);
            end
            wait_done8(cyc);
            checks++;
            if (bus8.done !== 1'b1 || cyc != 9) begin
                failures++;
                $display("[TB] FAIL add_latency case %0d: done=%b at cycle %0d, want done=1 at 9",
                         i, bus8.done, cyc);
            end
            e = sb8.pop_front();
            checks++;
            if ({bus8.sum, bus8.carry_out, bus8.overflow} !== {e.sum[7:0], e.co, e.ov}) begin
                failures++;
                $display("[TB] FAIL add_result case %0d: sum=%h co=%b ov=%b, want sum=%h co=%b ov=%b",
                         i, bus8.sum, bus8.carry_out, bus8.overflow, e.sum[7:0], e.co, e.ov);
            end
            @(negedge clk);
            checks++;
            if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.sum !== e.sum[7:0]) begin
                failures++;
                $display("[TB] FAIL add_hold case %0d: busy=%b done=%b sum=%h, want 0 0 %h",
                         i, bus8.busy, bus8.done, bus8.sum, e.sum[7:0]);
            end
        end
    endtask

    task automatic test_sub;
        logic [7:0] op_a [3] = '{8'h10, 8'h05, 8'h80};
        logic [7:0] op_b [3] = '{8'h20, 8'h03, 8'h01};
        bit         op_c [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] e_s  [3] = '{8'hF0, 8'h01, 8'h7F};
        bit         e_co [3] = '{1'b0, 1'b1, 1'b1};
        bit         e_ov [3] = '{1'b0, 1'b0, 1'b1};
        exp_t       e;
        int         cyc;
        for (int i = 0; i < 3; i++) begin
            start_op8(1'b1, op_a[i], op_b[i], op_c[i], '{32'(e_s[i]), e_co[i], e_ov[i]});
            wait_done8(cyc);
            checks++;
            if (bus8.done !== 1'b1 || cyc != 9) begin
                failures++;
                $display("[TB] FAIL sub_latency case %0d: done=%b at cycle %0d, want done=1 at 9",
                         i, bus8.done, cyc);
            end
            e = sb8.pop_front();
            checks++;
            if ({bus8.sum, bus8.carry_out, bus8.overflow} !== {e.sum[7:0], e.co, e.ov}) begin
                failures++;
                $display("[TB] FAIL sub_result case %0d: sum=%h co=%b ov=%b, want sum=%h co=%b ov=%b",
                         i, bus8.sum, bus8.carry_out, bus8.overflow, e.sum[7:0], e.co, e.ov);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_run;
        int   cyc;
        int   done_seen;
        exp_t e;
        bus8.mode    = 1'b0;
        bus8.a_input = 8'h07;
        bus8.b_input = 8'h00;
        bus8.c_in    = 1'b0;
        bus8.start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus8.busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_precondition: busy=%b, want 1", bus8.busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus8.busy, bus8.done, bus8.sum, bus8.carry_out, bus8.overflow} !== 12'h000) begin
            failures++;
            $display("[TB] FAIL abort_clear: busy=%b done=%b sum=%h co=%b ov=%b, want all 0",
                     bus8.busy, bus8.done, bus8.sum, bus8.carry_out, bus8.overflow);
        end
        rst_n     = 1'b1;
        done_seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus8.done === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0 || bus8.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_no_done: done pulses=%0d busy=%b, want 0 pulses busy=0",
                     done_seen, bus8.busy);
        end
        start_op8(1'b1, 8'h80, 8'h01, 1'b0, '{32'h7F, 1'b1, 1'b1});
        wait_done8(cyc);
        checks++;
        if (bus8.done !== 1'b1 || cyc != 9) begin
            failures++;
            $display("[TB] FAIL abort_fresh_latency: done=%b at cycle %0d, want done=1 at 9",
                     bus8.done, cyc);
        end
        e = sb8.pop_front();
        checks++;
        if ({bus8.sum, bus8.carry_out, bus8.overflow} !== {e.sum[7:0], e.co, e.ov}) begin
            failures++;
            $display("[TB] FAIL abort_fresh_result: sum=%h co=%b ov=%b, want sum=%h co=%b ov=%b",
                     bus8.sum, bus8.carry_out, bus8.overflow, e.sum[7:0], e.co, e.ov);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int   cyc;
        exp_t e;
        bus8.mode    = 1'b0;
        bus8.a_input = 8'h3C;
        bus8.b_input = 8'h05;
        bus8.c_in    = 1'b0;
        bus8.start   = 1'b1;
        sb8.push_back('{32'h41, 1'b0, 1'b0});
        @(posedge clk);
        @(negedge clk);
        bus8.a_input = 8'h11;
        bus8.b_input = 8'h22;
        bus8.c_in    = 1'b1;
        sb8.push_back('{32'h34, 1'b0, 1'b0});
        wait_done8(cyc);
        checks++;
        if (bus8.done !== 1'b1 || cyc != 9) begin
            failures++;
            $display("[TB] FAIL b2b_first_latency: done=%b at cycle %0d, want done=1 at 9", bus8.done, cyc);
        end
        e = sb8.pop_front();
        checks++;
        if ({bus8.sum, bus8.carry_out, bus8.overflow} !== {e.sum[7:0], e.co, e.ov}) begin
            failures++;
            $display("[TB] FAIL b2b_first_result: sum=%h co=%b ov=%b, want sum=%h co=%b ov=%b",
                     bus8.sum, bus8.carry_out, bus8.overflow, e.sum[7:0], e.co, e.ov);
        end
        @(negedge clk);
        checks++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.sum !== 8'h41) begin
            failures++;
            $display("[TB] FAIL b2b_idle_gap: busy=%b done=%b sum=%h, want 0 0 41",
                     bus8.busy, bus8.done, bus8.sum);
        end
        @(negedge clk);
        checks++;
        if (bus8.busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_second_start: busy=%b, want 1", bus8.busy);
        end
        bus8.start = 1'b0;
        wait_done8(cyc);
        checks++;
        if (bus8.done !== 1'b1 || cyc != 9) begin
            failures++;
            $display("[TB] FAIL b2b_second_latency: done=%b at cycle %0d, want done=1 at 9", bus8.done, cyc);
        end
        e = sb8.pop_front();
        checks++;
        if ({bus8.sum, bus8.carry_out, bus8.overflow} !== {e.sum[7:0], e.co, e.ov}) begin
            failures++;
            $display("[TB] FAIL b2b_second_result: sum=%h co=%b ov=%b, want sum=%h co=%b ov=%b",
                     bus8.sum, bus8.carry_out, bus8.overflow, e.sum[7:0], e.co, e.ov);
        end
        @(negedge clk);
    endtask

    task automatic test_width2;
        bit         m  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0] a  [6] = '{2'd1, 2'd3, 2'd1, 2'd0, 2'd2, 2'd3};
        logic [1:0] b  [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3};
        bit         ci [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_t       e;
        int         cyc;
        for (int i = 0; i < 6; i++) begin
            bus2.mode    = m[i];
            bus2.a_input = a[i];
            bus2.b_input = b[i];
            bus2.c_in    = ci[i];
            bus2.start   = 1'b1;
            sb2.push_back(model(2, m[i], 32'(a[i]), 32'(b[i]), ci[i]));
            @(posedge clk);
            @(negedge clk);
            bus2.start   = 1'b0;
            bus2.a_input = 2'($urandom);
            bus2.b_input = 2'($urandom);
            cyc = 1;
            while (bus2.done !== 1'b1 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            checks++;
            if (bus2.done !== 1'b1 || cyc != 3) begin
                failures++;
                $display("[TB] FAIL w2_latency case %0d: done=%b at cycle %0d, want done=1 at 3", i, bus2.done, cyc);
            end
            e = sb2.pop_front();
            checks++;
            if ({bus2.sum, bus2.carry_out, bus2.overflow} !== {e.sum[1:0], e.co, e.ov}) begin
                failures++;
                $display("[TB] FAIL w2_result case %0d: sum=%h co=%b ov=%b, want sum=%h co=%b ov=%b",
                         i, bus2.sum, bus2.carry_out, bus2.overflow, e.sum[1:0], e.co, e.ov);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_width32;
        bit          m  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] a  [6] = '{32'h3C, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h10, 32'h8000_0000, 32'h1234_5678};
        logic [31:0] b  [6] = '{32'h05, 32'h1, 32'h1, 32'h20, 32'h1, 32'h9ABC_DEF0};
        bit          ci [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_t        e;
        int          cyc;
        for (int i = 0; i < 6; i++) begin
            bus32.mode    = m[i];
            bus32.a_input = a[i];
            bus32.b_input = b[i];
            bus32.c_in    = ci[i];
            bus32.start   = 1'b1;
            sb32.push_back(model(32, m[i], a[i], b[i], ci[i]));
            @(posedge clk);
            @(negedge clk);
            bus32.start   = 1'b0;
            bus32.a_input = $urandom;
            bus32.b_input = $urandom;
            cyc = 1;
            while (bus32.done !== 1'b1 && cyc < 60) begin
                @(negedge clk);
                cyc++;
            end
            checks++;
            if (bus32.done !== 1'b1 || cyc != 33) begin
                failures++;
                $display("[TB] FAIL w32_latency case %0d: done=%b at cycle %0d, want done=1 at 33", i, bus32.done, cyc);
            end
            e = sb32.pop_front();
            checks++;
            if ({bus32.sum, bus32.carry_out, bus32.overflow} !== {e.sum, e.co, e.ov}) begin
                failures++;
                $display("[TB] FAIL w32_result case %0d: sum=%h co=%b ov=%b, want sum=%h co=%b ov=%b",
                         i, bus32.sum, bus32.carry_out, bus32.overflow, e.sum, e.co, e.ov);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_exhaustive;
        logic [17:0] idx;
        exp_t        e;
        int          cyc;
        for (int batch = 0; batch < (1 << 18) / LANES; batch++) begin
            for (int l = 0; l < LANES; l++) begin
                idx          = 18'(batch * LANES + l);
                lane_mode[l] = idx[17];
                lane_cin[l]  = idx[16];
                lane_a[l]    = idx[15:8];
                lane_b[l]    = idx[7:0];
                sb_lane.push_back(model(8, idx[17], 32'(idx[15:8]), 32'(idx[7:0]), idx[16]));
            end
            lane_start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            lane_start = 1'b0;
            cyc = 1;
            while (lane_done[0] !== 1'b1 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            checks++;
            if (lane_done[0] !== 1'b1 || cyc != 9) begin
                failures++;
                $display("[TB] FAIL sweep_latency batch %0d: done=%b at cycle %0d, want done=1 at 9",
                         batch, lane_done[0], cyc);
            end
            for (int l = 0; l < LANES; l++) begin
                e = sb_lane.pop_front();
                checks++;
                if ({lane_done[l], lane_sum[l], lane_co[l], lane_ov[l]} !== {1'b1, e.sum[7:0], e.co, e.ov}) begin
                    failures++;
                    $display("[TB] FAIL sweep m=%b ci=%b a=%h b=%h: done=%b sum=%h co=%b ov=%b, want 1 %h %b %b",
                             lane_mode[l], lane_cin[l], lane_a[l], lane_b[l], lane_done[l],
                             lane_sum[l], lane_co[l], lane_ov[l], e.sum[7:0], e.co, e.ov);
                end
            end
            @(negedge clk);
        end
    endtask

    // Test sequence.
    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus8.start    = 1'b0;
        bus8.mode     = 1'b0;
        bus8.a_input  = '0;
        bus8.b_input  = '0;
        bus8.c_in     = 1'b0;
        bus2.start    = 1'b0;
        bus2.mode     = 1'b0;
        bus2.a_input  = '0;
        bus2.b_input  = '0;
        bus2.c_in     = 1'b0;
        bus32.start   = 1'b0;
        bus32.mode    = 1'b0;
        bus32.a_input = '0;
        bus32.b_input = '0;
        bus32.c_in    = 1'b0;
        lane_start    = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            lane_mode[l] = 1'b0;
            lane_a[l]    = '0;
            lane_b[l]    = '0;
            lane_cin[l]  = 1'b0;
        end

        test_reset();
        test_add();
        test_sub();
        test_reset_mid_run();
        test_back_to_back();
        test_width2();
        test_width32();
        test_exhaustive();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
